// File: rtl/host_slave_responder.sv
// host_slave_responder
//
// Terminates the host-slave byte packet protocol inside the fabric. Request
// packets are popped from an inbound byte FIFO and decoded. Each read or write
// is executed against an internal word-addressed memory, and a response packet
// is pushed into an outbound byte FIFO.
//
// Ports:
//   CLK      in   single clock, rising edge
//   RESETn   in   asynchronous active-low reset
//   RDEN     out  pop request byte from inbound FIFO
//   RDEMPTY  in   inbound FIFO empty
//   RDDATA   in   inbound byte, valid the cycle after RDEN
//   WREN     out  push response byte to outbound FIFO
//   WRFULL   in   outbound FIFO full
//   WRDATA   out  response byte, valid while WREN is high
//   BUSY     out  packet in progress (header captured .. last response byte)
//   ERRCNT   out  saturating count of error responses
module host_slave_responder #(
    parameter int AW = 8
) (
    input  logic       CLK,
    input  logic       RESETn,
    output logic       RDEN,
    input  logic       RDEMPTY,
    input  logic [7:0] RDDATA,
    output logic       WREN,
    input  logic       WRFULL,
    output logic [7:0] WRDATA,
    output logic       BUSY,
    output logic [7:0] ERRCNT
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_EXEC  = 3'd4;
    localparam logic [2:0] S_RSTAT = 3'd5;
    localparam logic [2:0] S_RDATA = 3'd6;

    logic [2:0]    state;
    logic [1:0]    byte_cnt;
    logic [3:0]    pop_cnt;
    logic          rd_pend;
    logic [7:0]    hdr;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          resp_err;
    logic          resp_data;
    logic [31:0]   resp_word;
    logic [7:0]    err_cnt;
    logic [31:0]   mem [2**AW];

    logic          need_more;
    logic [3:0]    pkt_len;
    logic [1:0]    size;
    logic          req_err;
    logic [3:0]    lane_mask;
    logic [AW-1:0] mem_idx;

    assign pkt_len = hdr[7] ? 4'd9 : 4'd5;
    assign size    = hdr[5:4];
    assign mem_idx = addr[AW+1:2];

    // Pops are issued ahead of captures, so the budget counts bytes already
    // popped. While the header is still in flight the packet length is
    // unknown, but every packet is at least 5 bytes long.
    always_comb begin
        need_more = 1'b0;
        case (state)
            S_IDLE:          need_more = 1'b1;
            S_HDR:           need_more = (pop_cnt < 4'd5);
            S_ADDR, S_WDATA: need_more = (pop_cnt < pkt_len);
            default:         need_more = 1'b0;
        endcase
    end

    assign RDEN = need_more && !RDEMPTY;

    // Request checks and the write lane mask, used in the EXEC cycle.
    always_comb begin
        req_err = (size == 2'd3) || hdr[6] || (hdr[3:0] != 4'd0)
                  || ((size == 2'd1) && addr[0])
                  || ((size == 2'd2) && (addr[1:0] != 2'd0))
                  || (addr[31:AW+2] != '0);
        case (size)
            2'd0:    lane_mask = 4'b0001 << addr[1:0];
            2'd1:    lane_mask = addr[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    // Response side is combinational on WRFULL so that no byte is pushed
    // into a full FIFO and the state simply holds until space appears.
    always_comb begin
        WREN   = 1'b0;
        WRDATA = 8'h00;
        case (state)
            S_RSTAT: begin
                WREN   = !WRFULL;
                WRDATA = {7'd0, resp_err};
            end
            S_RDATA: begin
                WREN   = !WRFULL;
                WRDATA = resp_word[{byte_cnt, 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    assign BUSY   = (state != S_IDLE) && (state != S_HDR);
    assign ERRCNT = err_cnt;

    // Main control: captures arrive one cycle after their pop (rd_pend), and
    // the state only advances on a capture or on an accepted response byte.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= S_IDLE;
            byte_cnt  <= 2'd0;
            pop_cnt   <= 4'd0;
            rd_pend   <= 1'b0;
            hdr       <= 8'h00;
            addr      <= 32'd0;
            wdata     <= 32'd0;
            resp_err  <= 1'b0;
            resp_data <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            rd_pend <= RDEN;
            if (RDEN) begin
                pop_cnt <= (state == S_IDLE) ? 4'd1 : pop_cnt + 4'd1;
            end
            case (state)
                S_IDLE: begin
                    if (RDEN) state <= S_HDR;
                end
                S_HDR: begin
                    if (rd_pend) begin
                        hdr      <= RDDATA;
                        byte_cnt <= 2'd0;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (rd_pend) begin
                        addr[{byte_cnt, 3'b000} +: 8] <= RDDATA;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) state <= hdr[7] ? S_WDATA : S_EXEC;
                    end
                end
                S_WDATA: begin
                    if (rd_pend) begin
                        wdata[{byte_cnt, 3'b000} +: 8] <= RDDATA;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_err  <= req_err;
                    resp_data <= !req_err && !hdr[7];
                    byte_cnt  <= 2'd0;
                    if (req_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
                    state <= S_RSTAT;
                end
                S_RSTAT: begin
                    if (!WRFULL) state <= resp_data ? S_RDATA : S_IDLE;
                end
                S_RDATA: begin
                    if (!WRFULL) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory is not reset. The read word is latched before any write in the
    // same cycle, and an erroneous request never touches the array.
    always_ff @(posedge CLK) begin
        if (state == S_EXEC) begin
            resp_word <= mem[mem_idx];
            if (!req_err && hdr[7]) begin
                for (int i = 0; i < 4; i++) begin
                    if (lane_mask[i]) mem[mem_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_host_slave_responder.sv
// tb_host_slave_responder
//
// Drives host_slave_responder through modelled inbound/outbound byte FIFOs:
// a table of request/response packets, then hand-written sequences for
// backpressure with FIFO gaps, reset in the middle of a packet, and error
// counter saturation.
module tb_host_slave_responder;

    logic       CLK;
    logic       RESETn;
    logic       RDEN;
    logic       RDEMPTY;
    logic [7:0] RDDATA;
    logic       WREN;
    logic       WRFULL;
    logic [7:0] WRDATA;
    logic       BUSY;
    logic [7:0] ERRCNT;

    host_slave_responder #(.AW(8)) dut (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .RDEN    (RDEN),
        .RDEMPTY (RDEMPTY),
        .RDDATA  (RDDATA),
        .WREN    (WREN),
        .WRFULL  (WRFULL),
        .WRDATA  (WRDATA),
        .BUSY    (BUSY),
        .ERRCNT  (ERRCNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Request bytes are stored first-byte-at-MSB so the literals read in
    // wire order; response bytes likewise.
    typedef struct packed {
        logic [3:0]  req_len;
        logic [71:0] req;
        logic [2:0]  rsp_len;
        logic [39:0] rsp;
        logic [7:0]  errcnt;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    logic [7:0] inq [$];
    logic [7:0] outq [$];
    int  checks;
    int  errors;
    bit  pop_flag;
    bit  gap_mode;
    bit  gap_phase;
    int  full_left;
    int  full_seen;
    int  pop_total;

    function automatic vec_t mkv(input logic [3:0] rl, input logic [71:0] rq,
                                 input logic [2:0] sl, input logic [39:0] rs,
                                 input logic [7:0] ec);
        vec_t v;
        v.req_len = rl;
        v.req     = rq;
        v.rsp_len = sl;
        v.rsp     = rs;
        v.errcnt  = ec;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One clock of FIFO modelling: inputs change on the falling edge, the
    // DUT's combinational outputs are sampled 1 ns later.
    task automatic tick();
        @(negedge CLK);
        if (pop_flag && inq.size() > 0) RDDATA = inq.pop_front();
        gap_phase = ~gap_phase;
        RDEMPTY   = (inq.size() == 0) || (gap_mode && gap_phase);
        WRFULL    = (full_left > 0);
        if (full_left > 0) begin
            full_left--;
            full_seen++;
        end
        #1;
        pop_flag = RDEN;
        if (RDEN) pop_total++;
        if (RDEMPTY) check_output("rden_while_empty", {31'd0, RDEN}, 32'd0);
        if (WRFULL)  check_output("wren_while_full", {31'd0, WREN}, 32'd0);
        if (WREN) begin
            check_output("rden_during_response", {31'd0, RDEN}, 32'd0);
            outq.push_back(WRDATA);
        end
    endtask

    task automatic apply_stimulus(input logic [71:0] req, input int len);
        for (int i = 0; i < len; i++) inq.push_back(req[71-8*i -: 8]);
        outq.delete();
    endtask

    // Wait for a complete response and a drained request FIFO, then idle a
    // few cycles so any extra byte would show up in outq.
    task automatic wait_response(input int rsp_len, input int bound, input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < bound && !done; c++) begin
            tick();
            if (outq.size() >= rsp_len && inq.size() == 0 && !pop_flag && !BUSY) done = 1'b1;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("[TB] FAIL %s_timeout: got %0d response bytes expected %0d", name,
                     outq.size(), rsp_len);
        end
        for (int c = 0; c < 3; c++) tick();
    endtask

    task automatic compare_response(input logic [39:0] rsp, input int rsp_len,
                                    input logic [7:0] ec, input string name);
        check_output({name, "_rsp_len"}, outq.size(), rsp_len);
        for (int i = 0; i < rsp_len; i++) begin
            if (i < outq.size())
                check_output($sformatf("%s_byte%0d", name, i), {24'd0, outq[i]},
                             {24'd0, rsp[39-8*i -: 8]});
        end
        check_output({name, "_errcnt"}, {24'd0, ERRCNT}, {24'd0, ec});
        check_output({name, "_consumed"}, inq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int nerr;

        vecs[0]  = mkv(9, 72'hA0_20_00_00_00_EF_BE_AD_DE, 1, {8'h00, 32'h0}, 8'd0);
        vecs[1]  = mkv(5, {40'h00_20_00_00_00, 32'h0}, 5, 40'h00_EF_BE_AD_DE, 8'd0);
        vecs[2]  = mkv(9, 72'hA0_08_00_00_00_44_33_22_11, 1, {8'h00, 32'h0}, 8'd0);
        vecs[3]  = mkv(9, 72'h80_09_00_00_00_00_AA_00_00, 1, {8'h00, 32'h0}, 8'd0);
        vecs[4]  = mkv(5, {40'h20_08_00_00_00, 32'h0}, 5, 40'h00_44_AA_22_11, 8'd0);
        vecs[5]  = mkv(9, 72'hA0_00_00_00_00_0D_F0_FE_CA, 1, {8'h00, 32'h0}, 8'd0);
        vecs[6]  = mkv(9, 72'h90_03_00_00_00_55_66_77_88, 1, {8'h01, 32'h0}, 8'd1);
        vecs[7]  = mkv(5, {40'h20_00_00_00_00, 32'h0}, 5, 40'h00_0D_F0_FE_CA, 8'd1);
        vecs[8]  = mkv(5, {40'h20_00_04_00_00, 32'h0}, 1, {8'h01, 32'h0}, 8'd2);
        vecs[9]  = mkv(9, 72'h90_22_00_00_00_00_00_34_12, 1, {8'h00, 32'h0}, 8'd2);
        vecs[10] = mkv(5, {40'h20_20_00_00_00, 32'h0}, 5, 40'h00_EF_BE_34_12, 8'd2);
        vecs[11] = mkv(5, {40'h20_22_00_00_00, 32'h0}, 1, {8'h01, 32'h0}, 8'd3);
        vecs[12] = mkv(5, {40'h30_00_00_00_00, 32'h0}, 1, {8'h01, 32'h0}, 8'd4);
        vecs[13] = mkv(5, {40'h41_20_00_00_00, 32'h0}, 1, {8'h01, 32'h0}, 8'd5);
        vecs[14] = mkv(5, {40'h00_21_00_00_00, 32'h0}, 5, 40'h00_EF_BE_34_12, 8'd5);
        vecs[15] = mkv(9, 72'hA0_FC_03_00_00_01_02_03_04, 1, {8'h00, 32'h0}, 8'd5);
        vecs[16] = mkv(5, {40'h20_FC_03_00_00, 32'h0}, 5, 40'h00_01_02_03_04, 8'd5);
        vecs[17] = mkv(9, 72'hB0_20_00_00_00_FF_FF_FF_FF, 1, {8'h01, 32'h0}, 8'd6);
        vecs[18] = mkv(5, {40'h10_20_00_00_00, 32'h0}, 5, 40'h00_EF_BE_34_12, 8'd6);
        vecs[19] = mkv(5, {40'h20_00_00_00_80, 32'h0}, 1, {8'h01, 32'h0}, 8'd7);

        checks    = 0;
        errors    = 0;
        pop_flag  = 1'b0;
        gap_mode  = 1'b0;
        gap_phase = 1'b0;
        full_left = 0;
        full_seen = 0;
        pop_total = 0;
        RESETn    = 1'b0;
        RDEMPTY   = 1'b1;
        WRFULL    = 1'b0;
        RDDATA    = 8'h00;

        // Reset values
        repeat (2) @(negedge CLK);
        #1;
        check_output("reset_rden",   {31'd0, RDEN},   32'd0);
        check_output("reset_wren",   {31'd0, WREN},   32'd0);
        check_output("reset_wrdata", {24'd0, WRDATA}, 32'd0);
        check_output("reset_busy",   {31'd0, BUSY},   32'd0);
        check_output("reset_errcnt", {24'd0, ERRCNT}, 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;

        // Table of directed packets
        for (int v = 0; v < NVEC; v++) begin
            apply_stimulus(vecs[v].req, int'(vecs[v].req_len));
            wait_response(int'(vecs[v].rsp_len), 300, $sformatf("vec%0d", v));
            compare_response(vecs[v].rsp, int'(vecs[v].rsp_len), vecs[v].errcnt,
                             $sformatf("vec%0d", v));
        end

        // Backpressure in the read data phase with a gappy inbound FIFO
        gap_mode  = 1'b1;
        full_seen = 0;
        apply_stimulus({40'h20_20_00_00_00, 32'h0}, 5);
        begin
            bit armed;
            bit done;
            armed = 1'b0;
            done  = 1'b0;
            for (int c = 0; c < 300 && !done; c++) begin
                tick();
                if (!armed && outq.size() == 2) begin
                    full_left = 5;
                    armed     = 1'b1;
                end
                if (armed && full_left == 0 && outq.size() >= 5 && !BUSY) done = 1'b1;
            end
            if (!done) begin
                errors++;
                checks++;
                $display("[TB] FAIL bp_timeout: got %0d response bytes expected 5", outq.size());
            end
            for (int c = 0; c < 3; c++) tick();
        end
        gap_mode = 1'b0;
        check_output("bp_full_cycles", full_seen, 5);
        compare_response(40'h00_EF_BE_34_12, 5, 8'd7, "bp");

        // Reset after three bytes of a write; the write must be lost
        apply_stimulus(72'hA0_20_00_00_00_11_11_11_11, 9);
        begin
            int start;
            start = pop_total;
            for (int c = 0; c < 50 && (pop_total - start) < 3; c++) tick();
            check_output("rstmid_pops", pop_total - start, 3);
        end
        RESETn   = 1'b0;
        inq.delete();
        RDEMPTY  = 1'b1;
        pop_flag = 1'b0;
        #1;
        check_output("rstmid_rden",   {31'd0, RDEN},   32'd0);
        check_output("rstmid_wren",   {31'd0, WREN},   32'd0);
        check_output("rstmid_wrdata", {24'd0, WRDATA}, 32'd0);
        check_output("rstmid_busy",   {31'd0, BUSY},   32'd0);
        check_output("rstmid_errcnt", {24'd0, ERRCNT}, 32'd0);
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        apply_stimulus({40'h20_20_00_00_00, 32'h0}, 5);
        wait_response(5, 300, "rstmid_read");
        compare_response(40'h00_EF_BE_34_12, 5, 8'd0, "rstmid_read");

        // 256 back-to-back illegal-size requests saturate the error counter
        for (int p = 0; p < 256; p++) begin
            inq.push_back(8'h30);
            for (int b = 0; b < 4; b++) inq.push_back(8'h00);
        end
        outq.delete();
        wait_response(256, 6000, "sat");
        check_output("sat_rsp_len", outq.size(), 256);
        nerr = 0;
        foreach (outq[i]) if (outq[i] !== 8'h01) nerr++;
        check_output("sat_status_bytes", nerr, 0);
        check_output("sat_errcnt", {24'd0, ERRCNT}, 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
